// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared definitions for the EXE/MEM/WB stages of the 5-stage core:
//   bundle widths, bit offsets of every field in the EXE->MEM and MEM->WB
//   bundles, the load-kind enum and the helper that decodes the ld_* flags.
//
//   EXE->MEM bundle (EXE_BUS_W bits, MSB first):
//     {res_from_mem, gr_we, dest[4:0], alu_result[31:0], pc[31:0],
//      ld_b, ld_bu, ld_h, ld_hu, ld_w}
//   MEM->WB bundle (WB_BUS_W bits, MSB first):
//     {gr_we, dest[4:0], final_result[31:0], pc[31:0]}
package mem_stage_pkg;

    localparam int EXE_BUS_W = 76;
    localparam int WB_BUS_W  = 70;

    // EXE->MEM field offsets (LSB of each field; single bits are indices)
    localparam int EXE_LD_LSB       = 0;
    localparam int EXE_PC_LSB       = 5;
    localparam int EXE_ALU_LSB      = 37;
    localparam int EXE_DEST_LSB     = 69;
    localparam int EXE_GR_WE        = 74;
    localparam int EXE_RES_FROM_MEM = 75;

    // MEM->WB field offsets
    localparam int WB_PC_LSB     = 0;
    localparam int WB_RESULT_LSB = 32;
    localparam int WB_DEST_LSB   = 64;
    localparam int WB_GR_WE      = 69;

    typedef enum logic [2:0] {
        LOAD_W,
        LOAD_B,
        LOAD_BU,
        LOAD_H,
        LOAD_HU
    } load_kind_t;

    // ld_flags = {ld_b, ld_bu, ld_h, ld_hu, ld_w}. A load that sets no
    // flag (or only ld_w) is a full-word load.
    function automatic load_kind_t decode_load(input logic [4:0] ld_flags);
        load_kind_t kind;
        casez (ld_flags)
            5'b1????: kind = LOAD_B;
            5'b01???: kind = LOAD_BU;
            5'b001??: kind = LOAD_H;
            5'b0001?: kind = LOAD_HU;
            default:  kind = LOAD_W;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align
//   Purely combinational load-data aligner. Picks the byte/half/word out of
//   the SRAM read word according to the low address bits and sign- or
//   zero-extends it to 32 bits.
//   Ports:
//     rd        in  32  effective read word
//     off       in  2   alu_result[1:0] (byte offset within the word)
//     ld_flags  in  5   {ld_b, ld_bu, ld_h, ld_hu, ld_w}
//     load_data out 32  aligned, extended load result
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rd,
    input  logic [1:0]  off,
    input  logic [4:0]  ld_flags,
    output logic [31:0] load_data
);

    load_kind_t  kind;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword selection uses only off[1]; off[0] is ignored and there is
    // no misalignment trap.
    always_comb begin
        kind = decode_load(ld_flags);
        case (off)
            2'd0:    byte_sel = rd[7:0];
            2'd1:    byte_sel = rd[15:8];
            2'd2:    byte_sel = rd[23:16];
            default: byte_sel = rd[31:24];
        endcase
        half_sel = off[1] ? rd[31:16] : rd[15:0];
        case (kind)
            LOAD_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
            LOAD_BU: load_data = {24'd0, byte_sel};
            LOAD_H:  load_data = {{16{half_sel[15]}}, half_sel};
            LOAD_HU: load_data = {16'd0, half_sel};
            default: load_data = rd;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   Memory-access stage of the 5-stage core, between EXE and WB. Latches the
//   EXE->MEM bundle, takes the load word from the synchronous data SRAM (read
//   issued by EXE one cycle earlier), aligns/extends it, selects load data or
//   ALU result, forwards dest/value to ID and hands the result bundle to WB.
//   Single-cycle stage: an instruction leaves the cycle after it arrives
//   unless WB back-pressures.
//   Ports:
//     clk, reset        clock; synchronous active-high reset
//     WB_allow          in   WB can accept this cycle
//     EXE_to_MEM_valid  in   EXE bundle valid
//     EXE_to_MEM_bus    in   76-bit EXE->MEM bundle
//     data_sram_rdata   in   SRAM read word for the instruction in MEM
//     MEM_allow         out  MEM can accept from EXE
//     MEM_to_WB_valid   out  bundle to WB valid
//     MEM_to_WB_bus     out  70-bit MEM->WB bundle
//     MEM_dest_bus      out  bypass destination (0 = no write)
//     MEM_value_bus     out  bypass value
//   Configuration macro: MEM_RDATA_BUF_EN adds a one-word buffer that keeps
//   the SRAM read word alive while WB stalls this stage.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 WB_allow,
    input  logic                 EXE_to_MEM_valid,
    input  logic [EXE_BUS_W-1:0] EXE_to_MEM_bus,
    input  logic [31:0]          data_sram_rdata,
    output logic                 MEM_allow,
    output logic                 MEM_to_WB_valid,
    output logic [WB_BUS_W-1:0]  MEM_to_WB_bus,
    output logic [4:0]           MEM_dest_bus,
    output logic [31:0]          MEM_value_bus
);

    localparam logic MEM_GO = 1'b1;

    logic                 mem_valid;
    logic [EXE_BUS_W-1:0] bundle_q;
    logic [31:0]          rd;
    logic [31:0]          load_data;
    logic [31:0]          final_result;
    logic                 res_from_mem;
    logic                 gr_we;
    logic [4:0]           dest;
    logic [31:0]          alu_result;
    logic [31:0]          pc;

    assign MEM_allow       = ~mem_valid | (MEM_GO & WB_allow);
    assign MEM_to_WB_valid = mem_valid & MEM_GO;

    // Stage valid bit advances only when this stage can accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid <= 1'b0;
        end else if (MEM_allow) begin
            mem_valid <= EXE_to_MEM_valid;
        end
    end

    // Bundle register loads on a real transfer only, so a bubble leaves the
    // previous contents (and hence the outputs) untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            bundle_q <= '0;
        end else if (EXE_to_MEM_valid & MEM_allow) begin
            bundle_q <= EXE_to_MEM_bus;
        end
    end

`ifdef MEM_RDATA_BUF_EN
    logic [31:0] rdata_buf;
    logic        rdata_buf_vld;

    // EXE moves its address on while MEM is stalled, so the SRAM word is
    // only right in MEM's first valid cycle; capture it then and replay it
    // until the instruction is handed to WB.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_buf     <= '0;
            rdata_buf_vld <= 1'b0;
        end else if (mem_valid & WB_allow) begin
            rdata_buf_vld <= 1'b0;
        end else if (mem_valid & ~WB_allow & ~rdata_buf_vld) begin
            rdata_buf     <= data_sram_rdata;
            rdata_buf_vld <= 1'b1;
        end
    end

    assign rd = rdata_buf_vld ? rdata_buf : data_sram_rdata;
`else
    assign rd = data_sram_rdata;
`endif

    assign res_from_mem = bundle_q[EXE_RES_FROM_MEM];
    assign gr_we        = bundle_q[EXE_GR_WE];
    assign dest         = bundle_q[EXE_DEST_LSB +: 5];
    assign alu_result   = bundle_q[EXE_ALU_LSB +: 32];
    assign pc           = bundle_q[EXE_PC_LSB +: 32];

    mem_load_align u_load_align (
        .rd        (rd),
        .off       (alu_result[1:0]),
        .ld_flags  (bundle_q[EXE_LD_LSB +: 5]),
        .load_data (load_data)
    );

    assign final_result  = res_from_mem ? load_data : alu_result;
    assign MEM_value_bus = final_result;
    assign MEM_dest_bus  = (mem_valid & gr_we) ? dest : 5'd0;

    // Pack the MEM->WB bundle from the shared field offsets.
    always_comb begin
        MEM_to_WB_bus                         = '0;
        MEM_to_WB_bus[WB_GR_WE]               = gr_we;
        MEM_to_WB_bus[WB_DEST_LSB +: 5]       = dest;
        MEM_to_WB_bus[WB_RESULT_LSB +: 32]    = final_result;
        MEM_to_WB_bus[WB_PC_LSB +: 32]        = pc;
    end

endmodule
